ram_port_arbiter: RTL and testbench

//   Shares one single-port data RAM between the instruction-fetch master (I, read-only) and the load/store master (D, read/write).

---
 rtl/ram_port_arbiter_pkg.sv | 18 +
 rtl/rr_arb2.sv | 39 +++
 rtl/ram_port_arbiter.sv | 128 ++++++++++++
 tb/tb_ram_port_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_port_arbiter_pkg.sv
// Shared constants for the fetch/load-store RAM port arbiter:
// master IDs, the reset owner of the round-robin pointer and the lane shift.
package ram_port_arbiter_pkg;

    typedef enum logic {
        MST_I = 1'b0,
        MST_D = 1'b1
    } mst_t;

    // Pointer starts at D so that I wins the first tie.
    localparam mst_t RST_LAST = MST_D;

    // Number of low byte-address bits dropped to form a word index.
    function automatic int lane_shift(input int mw);
        return $clog2(mw);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with its last-grant pointer.
// Ports: clk, rst, i_elig_i/i_elig_d (eligible), o_gnt_i/o_gnt_d (one-hot grant).
module rr_arb2
    import ram_port_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_elig_i,
    input  logic i_elig_d,
    output logic o_gnt_i,
    output logic o_gnt_d
);

    mst_t r_last;

    always_comb begin
        o_gnt_i = 1'b0;
        o_gnt_d = 1'b0;
        if (i_elig_i && i_elig_d) begin
            // Tie: the master not served last goes first.
            o_gnt_i = (r_last == MST_D);
            o_gnt_d = (r_last == MST_I);
        end else begin
            o_gnt_i = i_elig_i;
            o_gnt_d = i_elig_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= RST_LAST;
        end else if (o_gnt_i) begin
            r_last <= MST_I;
        end else if (o_gnt_d) begin
            r_last <= MST_D;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port RAM between fetch (I, read-only) and load/store (D).
// Ports: I/D valid/ready request + response channels, ram_* side to the RAM.
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int DP = 512,
    parameter int DW = 32,
    parameter int MW = 4,
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req_valid,
    output logic          i_req_ready,
    input  logic [AW-1:0] i_req_addr,
    output logic          i_rsp_valid,
    input  logic          i_rsp_ready,
    output logic [DW-1:0] i_rsp_data,
    output logic          i_rsp_err,
    input  logic          d_req_valid,
    output logic          d_req_ready,
    input  logic [AW-1:0] d_req_addr,
    input  logic          d_req_we,
    input  logic [MW-1:0] d_req_sel,
    input  logic [DW-1:0] d_req_wdata,
    output logic          d_rsp_valid,
    input  logic          d_rsp_ready,
    output logic [DW-1:0] d_rsp_data,
    output logic          d_rsp_err,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    output logic [MW-1:0] ram_sel,
    output logic          ram_we,
    input  logic [DW-1:0] ram_rdata
);

    localparam int SH = lane_shift(MW);

    logic [AW-1:0] w_widx_i;
    logic [AW-1:0] w_widx_d;
    logic          w_rng_i;
    logic          w_rng_d;
    logic          w_elig_i;
    logic          w_elig_d;
    logic          w_gnt_i;
    logic          w_gnt_d;

    logic          r_i_vld;
    logic [DW-1:0] r_i_data;
    logic          r_i_err;
    logic          r_d_vld;
    logic [DW-1:0] r_d_data;
    logic          r_d_err;

    // Full-width compare: an address far above the RAM must not alias.
    assign w_widx_i = i_req_addr >> SH;
    assign w_widx_d = d_req_addr >> SH;
    assign w_rng_i  = (w_widx_i < AW'(DP));
    assign w_rng_d  = (w_widx_d < AW'(DP));

    // A master competes only if its response slot frees up this cycle;
    // nothing is accepted while reset is held.
    assign w_elig_i = !rst && i_req_valid && (!r_i_vld || i_rsp_ready);
    assign w_elig_d = !rst && d_req_valid && (!r_d_vld || d_rsp_ready);

    rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .i_elig_i (w_elig_i),
        .i_elig_d (w_elig_d),
        .o_gnt_i  (w_gnt_i),
        .o_gnt_d  (w_gnt_d)
    );

    assign i_req_ready = w_gnt_i;
    assign d_req_ready = w_gnt_d;

    always_comb begin
        ram_addr  = '0;
        ram_wdata = '0;
        ram_sel   = '0;
        ram_we    = 1'b0;
        if (w_gnt_d) begin
            ram_addr  = w_rng_d ? w_widx_d : '0;
            ram_wdata = d_req_wdata;
            ram_sel   = d_req_sel;
            ram_we    = d_req_we && w_rng_d;
        end else if (w_gnt_i) begin
            ram_addr  = w_rng_i ? w_widx_i : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_i_vld  <= 1'b0;
            r_i_data <= '0;
            r_i_err  <= 1'b0;
        end else if (w_gnt_i) begin
            r_i_vld  <= 1'b1;
            r_i_data <= w_rng_i ? ram_rdata : '0;
            r_i_err  <= !w_rng_i;
        end else if (i_rsp_ready) begin
            r_i_vld  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_d_vld  <= 1'b0;
            r_d_data <= '0;
            r_d_err  <= 1'b0;
        end else if (w_gnt_d) begin
            r_d_vld  <= 1'b1;
            r_d_data <= (w_rng_d && !d_req_we) ? ram_rdata : '0;
            r_d_err  <= !w_rng_d;
        end else if (d_rsp_ready) begin
            r_d_vld  <= 1'b0;
        end
    end

    assign i_rsp_valid = r_i_vld;
    assign i_rsp_data  = r_i_data;
    assign i_rsp_err   = r_i_err;
    assign d_rsp_valid = r_d_vld;
    assign d_rsp_data  = r_d_data;
    assign d_rsp_err   = r_d_err;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: directed scenarios plus random
// traffic against a word-array reference model of the shared RAM.
module tb_ram_port_arbiter;

    localparam int DP = 512;
    localparam int DW = 32;
    localparam int MW = 4;
    localparam int AW = 32;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } rsp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_req_valid = 1'b0;
    logic          i_req_ready;
    logic [AW-1:0] i_req_addr = '0;
    logic          i_rsp_valid;
    logic          i_rsp_ready = 1'b1;
    logic [DW-1:0] i_rsp_data;
    logic          i_rsp_err;
    logic          d_req_valid = 1'b0;
    logic          d_req_ready;
    logic [AW-1:0] d_req_addr = '0;
    logic          d_req_we = 1'b0;
    logic [MW-1:0] d_req_sel = '0;
    logic [DW-1:0] d_req_wdata = '0;
    logic          d_rsp_valid;
    logic          d_rsp_ready = 1'b1;
    logic [DW-1:0] d_rsp_data;
    logic          d_rsp_err;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [MW-1:0] ram_sel;
    logic          ram_we;
    logic [DW-1:0] ram_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mem     [DP];
    logic [31:0] ref_mem [DP];
    rsp_t qi[$];
    rsp_t qd[$];
    bit   last_d = 1'b1;
    bit   exp_vi = 1'b0;
    bit   exp_vd = 1'b0;
    int   acc_i = 0, acc_d = 0;
    int   seen_i = 0, seen_d = 0;

    always #5 clk = ~clk;

    ram_port_arbiter #(.DP(DP), .DW(DW), .MW(MW), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready),
        .i_req_addr(i_req_addr),
        .i_rsp_valid(i_rsp_valid), .i_rsp_ready(i_rsp_ready),
        .i_rsp_data(i_rsp_data), .i_rsp_err(i_rsp_err),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready),
        .d_req_addr(d_req_addr), .d_req_we(d_req_we),
        .d_req_sel(d_req_sel), .d_req_wdata(d_req_wdata),
        .d_rsp_valid(d_rsp_valid), .d_rsp_ready(d_rsp_ready),
        .d_rsp_data(d_rsp_data), .d_rsp_err(d_rsp_err),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_sel(ram_sel), .ram_we(ram_we), .ram_rdata(ram_rdata)
    );

    // The RAM itself, owned by the parent.
    assign ram_rdata = (ram_addr < 32'(DP)) ? mem[ram_addr[8:0]] : '0;

    always @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < MW; b++) begin
                if (ram_sel[b]) mem[ram_addr[8:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    // Reference: a word array accessed one transaction at a time.
    function automatic rsp_t model_access(input logic [31:0] addr, input bit we,
                                          input logic [3:0] sel, input logic [31:0] wd);
        rsp_t r;
        longint unsigned w;
        w = longint'(addr) / 4;
        r.data = '0;
        r.err  = 1'b0;
        if (w >= DP) begin
            r.err = 1'b1;
        end else if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (sel[b]) ref_mem[w][8*b +: 8] = wd[8*b +: 8];
            end
        end else begin
            r.data = ref_mem[w];
        end
        return r;
    endfunction

    // Request side: grant rule, RAM-port contents, and scoreboard pushes.
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            qi.delete();
            qd.delete();
            last_d = 1'b1;
        end else begin
            bit ei, ed, gi, gd, ri, rd;
            logic [31:0] e_addr;
            ri = (longint'(i_req_addr) / 4) < DP;
            rd = (longint'(d_req_addr) / 4) < DP;
            ei = i_req_valid && (!i_rsp_valid || i_rsp_ready);
            ed = d_req_valid && (!d_rsp_valid || d_rsp_ready);
            gi = ei && (!ed || last_d);
            gd = ed && (!ei || !last_d);
            chk("i_req_ready", 64'(i_req_ready), 64'(gi));
            chk("d_req_ready", 64'(d_req_ready), 64'(gd));
            chk("ram_we", 64'(ram_we), 64'(gd && d_req_we && rd));
            e_addr = '0;
            if (gd && rd) e_addr = d_req_addr / 4;
            else if (gi && ri) e_addr = i_req_addr / 4;
            chk("ram_addr", 64'(ram_addr), 64'(e_addr));
            if (gd) begin
                chk("ram_sel", 64'(ram_sel), 64'(d_req_sel));
                chk("ram_wdata", 64'(ram_wdata), 64'(d_req_wdata));
            end
            if (gi) last_d = 1'b0;
            if (gd) last_d = 1'b1;
            if (i_req_valid && i_req_ready) begin
                qi.push_back(model_access(i_req_addr, 1'b0, 4'h0, 32'h0));
                acc_i++;
            end
            if (d_req_valid && d_req_ready) begin
                qd.push_back(model_access(d_req_addr, d_req_we, d_req_sel, d_req_wdata));
                acc_d++;
            end
        end
    end

    // Response monitor: valid timing and scoreboard pops.
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            exp_vi = 1'b0;
            exp_vd = 1'b0;
        end else begin
            rsp_t r;
            chk("i_rsp_valid", 64'(i_rsp_valid), 64'(exp_vi));
            chk("d_rsp_valid", 64'(d_rsp_valid), 64'(exp_vd));
            if (i_rsp_valid && i_rsp_ready) begin
                if (qi.size() == 0) begin
                    chk("i_rsp_unexpected", 64'(i_rsp_valid), 64'(0));
                end else begin
                    r = qi.pop_front();
                    chk("i_rsp_data", 64'(i_rsp_data), 64'(r.data));
                    chk("i_rsp_err", 64'(i_rsp_err), 64'(r.err));
                end
            end
            if (d_rsp_valid && d_rsp_ready) begin
                if (qd.size() == 0) begin
                    chk("d_rsp_unexpected", 64'(d_rsp_valid), 64'(0));
                end else begin
                    r = qd.pop_front();
                    chk("d_rsp_data", 64'(d_rsp_data), 64'(r.data));
                    chk("d_rsp_err", 64'(d_rsp_err), 64'(r.err));
                end
            end
            if (i_req_valid && i_req_ready) exp_vi = 1'b1;
            else if (i_rsp_ready) exp_vi = 1'b0;
            if (d_req_valid && d_req_ready) exp_vd = 1'b1;
            else if (d_rsp_ready) exp_vd = 1'b0;
        end
    end

    function automatic logic [31:0] rand_addr();
        case ($urandom % 16)
            0:       return 32'(4 * DP) + ($urandom % 64);
            1:       return 32'hFFFF_FFFC | ($urandom % 4);
            2:       return 32'(4 * DP - 4) + ($urandom % 4);
            default: return ($urandom_range(0, DP - 1) << 2) | ($urandom % 4);
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_acc_i();
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            #1;
            if (acc_i != seen_i) break;
        end
        chk("i_accept_timeout", 64'(acc_i != seen_i), 64'(1));
        seen_i = acc_i;
        step();
    endtask

    task automatic wait_acc_d();
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            #1;
            if (acc_d != seen_d) break;
        end
        chk("d_accept_timeout", 64'(acc_d != seen_d), 64'(1));
        seen_d = acc_d;
        step();
    endtask

    task automatic rand_cycle();
        step();
        if (!i_req_valid || acc_i != seen_i) begin
            seen_i      = acc_i;
            i_req_valid = ($urandom % 4) != 0;
            i_req_addr  = rand_addr();
        end
        if (!d_req_valid || acc_d != seen_d) begin
            seen_d      = acc_d;
            d_req_valid = ($urandom % 4) != 0;
            d_req_addr  = rand_addr();
            d_req_we    = $urandom % 2;
            d_req_sel   = 4'($urandom);
            d_req_wdata = $urandom;
        end
        i_rsp_ready = ($urandom % 4) != 0;
        d_rsp_ready = ($urandom % 4) != 0;
    endtask

    initial begin
        for (int i = 0; i < DP; i++) begin
            ref_mem[i] = $urandom;
            mem[i] <= ref_mem[i];
        end
        ref_mem[4] = 32'hDEAD_BEEF;
        mem[4] <= 32'hDEAD_BEEF;

        // Reset state, with requests pending so readiness is meaningful.
        i_req_valid = 1'b1;
        d_req_valid = 1'b1;
        #1;
        chk("rst_i_req_ready", 64'(i_req_ready), 64'(0));
        chk("rst_d_req_ready", 64'(d_req_ready), 64'(0));
        chk("rst_ram_we", 64'(ram_we), 64'(0));
        chk("rst_i_rsp_valid", 64'(i_rsp_valid), 64'(0));
        chk("rst_d_rsp_valid", 64'(d_rsp_valid), 64'(0));
        chk("rst_rsp_data", 64'({i_rsp_data, d_rsp_data}), 64'(0));
        chk("rst_rsp_err", 64'({i_rsp_err, d_rsp_err}), 64'(0));
        i_req_valid = 1'b0;
        d_req_valid = 1'b0;
        repeat (3) step();
        rst = 1'b0;

        // Single fetch of the preloaded word.
        i_req_valid = 1'b1;
        i_req_addr  = 32'h10;
        wait_acc_i();
        i_req_valid = 1'b0;
        step();

        // Both requesting continuously: grants must alternate.
        i_req_valid = 1'b1;
        i_req_addr  = 32'h44;
        d_req_valid = 1'b1;
        d_req_we    = 1'b0;
        d_req_addr  = 32'h48;
        repeat (8) step();
        i_req_valid = 1'b0;
        d_req_valid = 1'b0;
        step();
        seen_i = acc_i;
        seen_d = acc_d;

        // Byte-lane write followed by a read-back of the merged word.
        d_req_valid = 1'b1;
        d_req_we    = 1'b1;
        d_req_addr  = 32'h20;
        d_req_sel   = 4'b0010;
        d_req_wdata = 32'h0000_AB00;
        wait_acc_d();
        d_req_we = 1'b0;
        wait_acc_d();

        // Out-of-range write, then reads proving nothing was written.
        d_req_we    = 1'b1;
        d_req_addr  = 32'h800;
        d_req_sel   = 4'hF;
        d_req_wdata = 32'hCAFE_F00D;
        wait_acc_d();
        d_req_we   = 1'b0;
        d_req_addr = 32'h0;
        wait_acc_d();
        d_req_addr = 32'h800;
        wait_acc_d();
        d_req_valid = 1'b0;
        step();

        // Fetch response held: D keeps being served, then I resumes.
        i_req_valid = 1'b1;
        i_req_addr  = 32'h30;
        d_req_valid = 1'b1;
        d_req_addr  = 32'h34;
        i_rsp_ready = 1'b0;
        repeat (6) step();
        i_rsp_ready = 1'b1;
        repeat (4) step();
        i_req_valid = 1'b0;
        d_req_valid = 1'b0;
        step();
        seen_i = acc_i;
        seen_d = acc_d;

        repeat (1500) rand_cycle();

        // Reset in the middle of traffic with a D response pending.
        step();
        d_req_valid = 1'b1;
        d_req_we    = 1'b0;
        d_req_addr  = 32'h40;
        d_rsp_ready = 1'b0;
        i_req_valid = 1'b1;
        i_req_addr  = 32'h50;
        repeat (3) step();
        #1;
        chk("pre_rst_d_rsp_valid", 64'(d_rsp_valid), 64'(1));
        rst = 1'b1;
        #1;
        chk("mid_rst_rsp_valid", 64'({i_rsp_valid, d_rsp_valid}), 64'(0));
        chk("mid_rst_req_ready", 64'({i_req_ready, d_req_ready}), 64'(0));
        chk("mid_rst_ram_we", 64'(ram_we), 64'(0));
        repeat (2) step();
        d_rsp_ready = 1'b1;
        i_rsp_ready = 1'b1;
        seen_i = acc_i;
        seen_d = acc_d;
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("post_rst_tie_i", 64'(i_req_ready), 64'(1));
        chk("post_rst_tie_d", 64'(d_req_ready), 64'(0));

        repeat (1500) rand_cycle();

        step();
        i_req_valid = 1'b0;
        d_req_valid = 1'b0;
        i_rsp_ready = 1'b1;
        d_rsp_ready = 1'b1;
        repeat (4) step();
        chk("i_queue_drained", 64'(qi.size()), 64'(0));
        chk("d_queue_drained", 64'(qd.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
